// File: rtl/rx_word_aligner_pkg.sv
// Shared aligner types plus the 3b/4b and 5b/6b sub-block code tables used by both
// the receive decoder and the transmit encoder.
package rx_word_aligner_pkg;

    typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} align_state_t;

    localparam logic [9:0] SYNC_WORD_DEFAULT = 10'b1111100000;

    // Index is the data value; NEG/POS are the two running-disparity forms (equal when balanced).
    localparam logic [5:0] CODE6_NEG [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] CODE6_POS [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    localparam logic [3:0] CODE4_NEG [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] CODE4_POS [8] = '{
        4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    localparam logic [3:0] CODE4_A7_NEG = 4'b0111;
    localparam logic [3:0] CODE4_A7_POS = 4'b1000;

    typedef struct packed {
        logic       illegal;
        logic [4:0] val;
    } dec6_t;

    typedef struct packed {
        logic       illegal;
        logic [2:0] val;
    } dec4_t;

    // The encoder picks the alternate x.7 form itself; only the primary form lives here.
    function automatic logic [5:0] enc_5b6b(input logic [4:0] val, input logic rd_pos);
        return rd_pos ? CODE6_POS[val] : CODE6_NEG[val];
    endfunction

    function automatic logic [3:0] enc_3b4b(input logic [2:0] val, input logic rd_pos);
        return rd_pos ? CODE4_POS[val] : CODE4_NEG[val];
    endfunction

    function automatic dec6_t dec_6b5b(input logic [5:0] code);
        dec6_t r;
        r.illegal = 1'b1;
        r.val     = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (code == CODE6_NEG[5'(i)] || code == CODE6_POS[5'(i)]) begin
                r.illegal = 1'b0;
                r.val     = 5'(i);
            end
        end
        return r;
    endfunction

    function automatic dec4_t dec_4b3b(input logic [3:0] code);
        dec4_t r;
        r.illegal = 1'b1;
        r.val     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (code == CODE4_NEG[3'(i)] || code == CODE4_POS[3'(i)]) begin
                r.illegal = 1'b0;
                r.val     = 3'(i);
            end
        end
        if (code == CODE4_A7_NEG || code == CODE4_A7_POS) begin
            r.illegal = 1'b0;
            r.val     = 3'd7;
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_word_aligner_dec_10b8b_comb.sv
// Combinational 10b->8b word decoder: bits[9:6] give data[7:5], bits[5:0] give data[4:0];
// an illegal sub-block decodes to zero in its field and raises illegal.
module dec_10b8b_comb
    import rx_word_aligner_pkg::*;
(
    input  logic [9:0] code,
    output logic [7:0] data,
    output logic       illegal
);

    dec4_t d4;
    dec6_t d6;

    always_comb begin
        d4      = dec_4b3b(code[9:6]);
        d6      = dec_6b5b(code[5:0]);
        data    = {d4.val, d6.val};
        illegal = d4.illegal | d6.illegal;
    end

endmodule

// File: rtl/rx_word_aligner.sv
// Serial word aligner: hunts for SYNC_WORD, verifies LOCK_CNT aligned syncs, then decodes words.
// Define RX_ALIGN_STATS_EN to build the saturating err_count statistics counter.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_HUNT   | sliding bit-by-bit search for SYNC_WORD
// ST_VERIFY | boundary found, counting consecutive aligned sync words
// ST_LOCKED | aligned; data words decoded, syncs consumed, error runs tracked
module rx_word_aligner
    import rx_word_aligner_pkg::*;
#(
    parameter logic [9:0]  SYNC_WORD = SYNC_WORD_DEFAULT,
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned ERR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ser_in,
    input  logic        bit_en,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        code_err,
    output logic        locked,
    output logic [15:0] err_count
);

    localparam logic [3:0] LOCK_TC = 4'(LOCK_CNT);
    localparam logic [3:0] ERR_TC  = 4'(ERR_LIMIT);

    align_state_t state, state_nxt;
    logic [8:0]   shreg, shreg_nxt;
    logic [9:0]   window;
    logic [3:0]   bit_cnt, bit_cnt_nxt;
    logic [3:0]   sync_cnt, sync_cnt_nxt;
    logic [3:0]   err_run, err_run_nxt;
    logic [7:0]   data_nxt, dec_data;
    logic         dv_nxt, cerr_nxt, dec_illegal, word_done;

    assign window    = {shreg, ser_in};
    assign word_done = (bit_cnt == 4'd9);
    assign locked    = (state == ST_LOCKED);

    dec_10b8b_comb u_dec (
        .code    (window),
        .data    (dec_data),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        bit_cnt_nxt  = bit_cnt;
        sync_cnt_nxt = sync_cnt;
        err_run_nxt  = err_run;
        data_nxt     = data_out;
        dv_nxt       = 1'b0;
        cerr_nxt     = 1'b0;
        if (bit_en) begin
            shreg_nxt   = window[8:0];
            bit_cnt_nxt = word_done ? 4'd0 : bit_cnt + 4'd1;
            case (state)
                ST_HUNT: begin
                    bit_cnt_nxt = 4'd0;
                    if (window == SYNC_WORD) begin
                        sync_cnt_nxt = 4'd1;
                        err_run_nxt  = 4'd0;
                        state_nxt    = (LOCK_TC == 4'd1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (word_done) begin
                        if (window == SYNC_WORD) begin
                            sync_cnt_nxt = sync_cnt + 4'd1;
                            if (sync_cnt + 4'd1 == LOCK_TC) state_nxt = ST_LOCKED;
                        end else begin
                            sync_cnt_nxt = 4'd0;
                            state_nxt    = ST_HUNT;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (word_done) begin
                        if (window == SYNC_WORD) begin
                            err_run_nxt = 4'd0;
                        end else begin
                            dv_nxt   = 1'b1;
                            data_nxt = dec_data;
                            cerr_nxt = dec_illegal;
                            if (!dec_illegal) begin
                                err_run_nxt = 4'd0;
                            end else if (err_run + 4'd1 == ERR_TC) begin
                                // The failing word is still reported; the drop takes effect with it.
                                state_nxt    = ST_HUNT;
                                err_run_nxt  = 4'd0;
                                sync_cnt_nxt = 4'd0;
                                bit_cnt_nxt  = 4'd0;
                            end else begin
                                err_run_nxt = err_run + 4'd1;
                            end
                        end
                    end
                end
                default: state_nxt = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HUNT;
            shreg      <= '0;
            bit_cnt    <= '0;
            sync_cnt   <= '0;
            err_run    <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            sync_cnt   <= sync_cnt_nxt;
            err_run    <= err_run_nxt;
            data_out   <= data_nxt;
            data_valid <= dv_nxt;
            code_err   <= cerr_nxt;
        end
    end

`ifdef RX_ALIGN_STATS_EN
    logic [15:0] err_count_q;
    logic [16:0] err_sum;
    logic        drop_lock;

    assign drop_lock = (state == ST_LOCKED) && (state_nxt == ST_HUNT);
    assign err_sum   = {1'b0, err_count_q} + {16'h0000, cerr_nxt} + {16'h0000, drop_lock};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_count_q <= 16'h0000;
        else        err_count_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    assign err_count = err_count_q;
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_rx_word_aligner.sv
// Self-checking bench for rx_word_aligner: vector table, directed corner sequences and a
// randomized bit stream compared against a word-level reference model.
module tb_rx_word_aligner;

    localparam logic [9:0] SYNC   = 10'b1111100000;
    localparam int         LOCK_N = 3;
    localparam int         ERR_N  = 4;
    localparam int         M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ser_in = 1'b0;
    logic        bit_en = 1'b0;
    logic [7:0]  data_out;
    logic        data_valid, code_err, locked;
    logic [15:0] err_count;

    rx_word_aligner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_in     (ser_in),
        .bit_en     (bit_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .code_err   (code_err),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Reference code book (abcdei for 5b/6b, fghj for 3b/4b), both disparities.
    logic [5:0] t6n [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [5:0] t6p [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    logic [3:0] t4n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] t4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    int dec6 [64];
    int dec4 [16];

    typedef struct {
        logic [9:0] word;
        logic [7:0] data;
        logic       err;
    } vec_t;
    vec_t vecs [12];

    int n_cmp = 0, n_fail = 0;
    int n_dv = 0, n_cerr = 0;
    logic       seen_dv;
    logic [7:0] seen_data;
    logic       seen_cerr;

    // Reference model state: full bit history since reset plus the next word boundary.
    logic       hist [$];
    int         anchor, m_mode, m_syncs, m_run, m_errs;
    logic [7:0] m_data;
    logic       m_dv, m_cerr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void build_tables();
        for (int i = 0; i < 64; i++) dec6[i] = -1;
        for (int i = 0; i < 16; i++) dec4[i] = -1;
        for (int i = 0; i < 32; i++) begin
            dec6[t6n[i]] = i;
            dec6[t6p[i]] = i;
        end
        for (int i = 0; i < 8; i++) begin
            dec4[t4n[i]] = i;
            dec4[t4p[i]] = i;
        end
        dec4[4'b0111] = 7;
        dec4[4'b1000] = 7;
    endfunction

    function automatic void ref_decode(input logic [9:0] w, output logic [7:0] d, output logic ill);
        int hi, lo;
        hi  = dec4[w[9:6]];
        lo  = dec6[w[5:0]];
        ill = (hi < 0) || (lo < 0);
        d   = 8'(((hi < 0) ? 0 : hi) * 32 + ((lo < 0) ? 0 : lo));
    endfunction

    function automatic logic [9:0] word_at(input int start);
        logic [9:0] w;
        w = '0;
        for (int k = 0; k < 10; k++) w = {w[8:0], hist[start + k]};
        return w;
    endfunction

    function automatic void model_reset();
        hist.delete();
        anchor  = 0;
        m_mode  = M_HUNT;
        m_syncs = 0;
        m_run   = 0;
        m_errs  = 0;
        m_data  = 8'h00;
        m_dv    = 1'b0;
        m_cerr  = 1'b0;
    endfunction

    function automatic void model_bit(input logic b);
        logic [9:0] w;
        logic [7:0] d;
        logic       ill;
        m_dv   = 1'b0;
        m_cerr = 1'b0;
        hist.push_back(b);
        if (m_mode == M_HUNT) begin
            if (hist.size() >= 10 && word_at(hist.size() - 10) == SYNC) begin
                anchor  = hist.size();
                m_syncs = 1;
                m_run   = 0;
                m_mode  = (LOCK_N == 1) ? M_LOCKED : M_VERIFY;
            end
        end else if (hist.size() - anchor == 10) begin
            w = word_at(anchor);
            anchor += 10;
            if (m_mode == M_VERIFY) begin
                if (w == SYNC) begin
                    m_syncs++;
                    if (m_syncs == LOCK_N) m_mode = M_LOCKED;
                end else begin
                    m_mode = M_HUNT;
                end
            end else if (w == SYNC) begin
                m_run = 0;
            end else begin
                ref_decode(w, d, ill);
                m_dv   = 1'b1;
                m_cerr = ill;
                m_data = d;
                if (ill) begin
                    m_run++;
                    m_errs++;
                end else begin
                    m_run = 0;
                end
                if (m_run == ERR_N) begin
                    m_mode = M_HUNT;
                    m_run  = 0;
                    m_errs++;
                end
            end
        end
    endfunction

    function automatic logic [15:0] exp_errs();
`ifdef RX_ALIGN_STATS_EN
        return (m_errs > 65535) ? 16'hFFFF : 16'(m_errs);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check_cycle(input string tag);
        chk({tag, "_data_valid"}, 32'(data_valid), 32'(m_dv));
        chk({tag, "_code_err"}, 32'(code_err), 32'(m_cerr));
        chk({tag, "_locked"}, 32'(locked), 32'(m_mode == M_LOCKED));
        chk({tag, "_data_out"}, 32'(data_out), 32'(m_data));
        chk({tag, "_err_count"}, 32'(err_count), 32'(exp_errs()));
        if (data_valid === 1'b1) begin
            n_dv++;
            seen_dv   = 1'b1;
            seen_data = data_out;
            seen_cerr = code_err;
            if (code_err === 1'b1) n_cerr++;
        end
    endtask

    // Called at a falling edge; returns at a falling edge after the checks.
    task automatic send_bit(input logic b, input int gap, input string tag);
        ser_in = b;
        bit_en = 1'b1;
        model_bit(b);
        @(negedge clk);
        check_cycle(tag);
        m_dv   = 1'b0;
        m_cerr = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bit_en = 1'b0;
            ser_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_cycle(tag);
        end
        bit_en = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] w, input int gap, input string tag);
        logic [9:0] s;
        s       = w;
        seen_dv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_bit(s[9], gap, tag);
            s = s << 1;
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        bit_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_cycle("reset");
        rst_n = 1'b1;
    endtask

    task automatic lock_up(input string tag);
        for (int i = 0; i < LOCK_N; i++) send_word(SYNC, 0, tag);
        chk({tag, "_locked_after_syncs"}, 32'(locked), 32'd1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv0, cerr0, gap, sel;
        logic [7:0] v;
        logic [9:0] w;

        build_tables();
        vecs[0]  = '{10'b1010101001, 8'hA5, 1'b0};
        vecs[1]  = '{10'b0100011000, 8'h00, 1'b0};
        vecs[2]  = '{10'b1011100111, 8'h00, 1'b0};
        vecs[3]  = '{10'b1111111111, 8'h00, 1'b1};
        vecs[4]  = '{10'b1001011101, 8'h21, 1'b0};
        vecs[5]  = '{10'b0111100011, 8'hF1, 1'b0};
        vecs[6]  = '{10'b0000101001, 8'h05, 1'b1};
        vecs[7]  = '{10'b1110011110, 8'hFE, 1'b0};
        vecs[8]  = '{10'b1010111111, 8'hA0, 1'b1};
        vecs[9]  = '{10'b0001010100, 8'hFF, 1'b0};
        vecs[10] = '{10'b1001001111, 8'h20, 1'b1};
        vecs[11] = '{10'b0101110001, 8'h43, 1'b0};

        @(negedge clk);
        do_reset();

        // Basic acquisition and first decode.
        send_word(SYNC, 0, "acq_s1");
        chk("acq_locked_s1", 32'(locked), 32'd0);
        send_word(SYNC, 0, "acq_s2");
        chk("acq_locked_s2", 32'(locked), 32'd0);
        send_word(SYNC, 0, "acq_s3");
        chk("acq_locked_s3", 32'(locked), 32'd1);
        dv0 = n_dv;
        send_word(10'b1010101001, 0, "acq_a5");
        chk("acq_a5_dv", 32'(seen_dv), 32'd1);
        chk("acq_a5_data", 32'(seen_data), 32'hA5);
        chk("acq_a5_cerr", 32'(seen_cerr), 32'd0);
        chk("acq_a5_pulses", 32'(n_dv - dv0), 32'd1);

        // Vector table while locked.
        for (int i = 0; i < 12; i++) begin
            send_word(vecs[i].word, 0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_dv", i), 32'(seen_dv), 32'd1);
            chk($sformatf("vec%0d_data", i), 32'(seen_data), 32'(vecs[i].data));
            chk($sformatf("vec%0d_err", i), 32'(seen_cerr), 32'(vecs[i].err));
        end

        // Sparse bit_en (one bit in three) must decode identically.
        for (int i = 0; i < 3; i++) begin
            send_word(vecs[i * 4 + 1].word, 2, $sformatf("sparse%0d", i));
            chk($sformatf("sparse%0d_data", i), 32'(seen_data), 32'(vecs[i * 4 + 1].data));
            chk($sformatf("sparse%0d_err", i), 32'(seen_cerr), 32'(vecs[i * 4 + 1].err));
        end

        // Misaligned garbage ahead of the syncs.
        do_reset();
        send_bit(1'b1, 0, "garb");
        send_bit(1'b0, 0, "garb");
        send_bit(1'b1, 0, "garb");
        send_bit(1'b1, 0, "garb");
        send_bit(1'b0, 0, "garb");
        lock_up("garb");
        send_word(10'b0100011000, 0, "garb_d00");
        chk("garb_d00_dv", 32'(seen_dv), 32'd1);
        chk("garb_d00_data", 32'(seen_data), 32'h00);

        // VERIFY broken by a data word falls back to HUNT.
        do_reset();
        dv0 = n_dv;
        send_word(SYNC, 0, "ver");
        send_word(10'b0100011000, 0, "ver_brk");
        send_word(SYNC, 0, "ver");
        send_word(SYNC, 0, "ver");
        chk("ver_not_locked", 32'(locked), 32'd0);
        chk("ver_no_dv", 32'(n_dv - dv0), 32'd0);
        send_word(SYNC, 0, "ver");
        chk("ver_relocked", 32'(locked), 32'd1);

        // Error run to the limit drops lock.
        do_reset();
        lock_up("erun");
        cerr0 = n_cerr;
        for (int i = 0; i < ERR_N; i++) begin
            send_word(10'b1111111111, 0, "erun");
            chk($sformatf("erun%0d_locked", i), 32'(locked), (i == ERR_N - 1) ? 32'd0 : 32'd1);
        end
        chk("erun_cerr_pulses", 32'(n_cerr - cerr0), 32'(ERR_N));
`ifdef RX_ALIGN_STATS_EN
        chk("erun_err_count", 32'(err_count), 32'd5);
`else
        chk("erun_err_count", 32'(err_count), 32'd0);
`endif

        // Asynchronous reset in the middle of a locked word.
        do_reset();
        lock_up("mid");
        send_word(10'b1010101001, 0, "mid_a5");
        w = 10'b1010101001;
        for (int i = 0; i < 5; i++) begin
            send_bit(w[9], 0, "mid_part");
            w = w << 1;
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_locked", 32'(locked), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'h00);
        chk("mid_rst_dv", 32'(data_valid), 32'd0);
        chk("mid_rst_cerr", 32'(code_err), 32'd0);
        chk("mid_rst_errcnt", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dv0 = n_dv;
        for (int i = 0; i < 5; i++) begin
            send_bit(w[9], 0, "mid_rest");
            w = w << 1;
        end
        send_word(10'b1010101001, 0, "mid_post");
        send_word(SYNC, 0, "mid_post");
        send_word(10'b1010101001, 0, "mid_post");
        chk("mid_no_dv", 32'(n_dv - dv0), 32'd0);
        chk("mid_not_locked", 32'(locked), 32'd0);

        // Randomized stream against the reference model.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            sel = int'($urandom_range(0, 9));
            if (sel <= 3) begin
                send_word(SYNC, gap, "rnd_sync");
            end else if (sel <= 6) begin
                v = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) w = {t4p[v[7:5]], t6p[v[4:0]]};
                else                           w = {t4n[v[7:5]], t6n[v[4:0]]};
                send_word(w, gap, "rnd_data");
            end else if (sel == 7) begin
                send_word(10'($urandom_range(0, 1023)), gap, "rnd_word");
            end else if (sel == 8) begin
                send_word(10'b1111111111, gap, "rnd_ones");
            end else begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                    send_bit(1'($urandom_range(0, 1)), gap, "rnd_slip");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_word_aligner.md
RX_WORD_ALIGNER -- requirements
Module: rx_word_aligner

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 10'b1111100000, 10-bit comma pattern that is never a legal data code.
REQ-002 SHALL have parameter LOCK_CNT, default 3, number of consecutive aligned sync words required to declare lock (range 1..15).
REQ-003 SHALL have parameter ERR_LIMIT, default 4, number of consecutive code errors that drops lock (range 1..15).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ser_in, input, 1, serial line bit, sampled only when bit_en=1.
REQ-007 SHALL have port bit_en, input, 1, qualifies ser_in, one bit per asserted cycle.
REQ-008 SHALL have port data_out, output, 8, decoded byte of last completed word.
REQ-009 SHALL have port data_valid, output, 1, one-cycle pulse per decoded data word while locked.
REQ-010 SHALL have port code_err, output, 1, one-cycle pulse with data_valid when the word is not a legal code.
REQ-011 SHALL have port locked, output, 1, high in state LOCKED.
REQ-012 SHALL have port err_count, output, 16, saturating error counter (see Configuration).

Function
REQ-013 SHALL shift MSB-first on bit_en: window = {shreg[8:0], ser_in}; first received bit ends in bit 9.
REQ-014 SHALL implement states HUNT, VERIFY, LOCKED; reset state HUNT.
REQ-015 HUNT: on bit_en with window==SYNC_WORD SHALL go VERIFY, clear bit counter to 0, set sync count to 1 (LOCKED directly if LOCK_CNT=1).
REQ-016 VERIFY/LOCKED: bit counter 0..9 SHALL wrap on each bit_en; a word completes on the bit_en where counter wraps 9->0.
REQ-017 VERIFY: completed word==SYNC_WORD increments sync count; reaching LOCK_CNT -> LOCKED; any other word -> HUNT, count cleared.
REQ-018 LOCKED: completed word==SYNC_WORD SHALL be consumed silently (no data_valid) and SHALL clear the error run count.
REQ-019 LOCKED: other completed words SHALL be decoded: bits[9:6] via 4b->3b table to data_out[7:5], bits[5:0] via 6b->5b table to data_out[4:0], using the team 8b/10b code tables.
REQ-020 Illegal nibble or sextet SHALL set that field to 0, pulse code_err, increment error run; legal word clears error run.
REQ-021 Error run reaching ERR_LIMIT SHALL force HUNT next cycle, deassert locked, clear counters; the erroring word still emits data_valid/code_err.
REQ-022 data_valid/data_out SHALL appear registered, exactly one clk after the bit_en cycle supplying the word's 10th bit.
REQ-023 bit_en=0 SHALL hold shreg, bit counter, state; data_out holds last value.
REQ-024 HUNT/VERIFY SHALL never pulse data_valid or code_err.

Reset
REQ-025 rst_n low SHALL asynchronously set state HUNT, shreg 0, all counters 0, data_out 8'h00, data_valid 0, code_err 0, locked 0, err_count 0.
REQ-026 Reset mid-word SHALL discard partial bits; re-acquisition requires full HUNT/VERIFY sequence.

Configuration
REQ-027 With RX_ALIGN_STATS_EN defined, err_count SHALL increment on each code_err pulse and on each LOCKED->HUNT transition (both in same cycle count +2), saturating at 16'hFFFF.
REQ-028 Without RX_ALIGN_STATS_EN, err_count SHALL be constant 16'h0000 and no counter flops are built.

Structure
REQ-029 Shared package SHALL hold state enum, SYNC_WORD default, and the 3b<->4b and 5b<->6b code tables/functions shared with the encoder.
REQ-030 Decode SHALL be a sub-module dec_10b8b_comb (pure combinational, outputs byte and illegal flag).

Verification
REQ-031 Reset, then 3 aligned SYNC_WORD + word 10'b1010101001 -> locked=1 after 3rd sync, data_out=8'hA5, data_valid one pulse, code_err=0.
REQ-032 5 garbage bits then 3 SYNC_WORD -> lock acquired at correct boundary; following 10'b0100011000 -> data_out=8'h00.
REQ-033 Locked, 4 consecutive 10'b1111111111 -> 4 code_err pulses, locked drops after 4th, err_count=5 with macro, 0 without.
REQ-034 VERIFY after 1 sync, then word 10'b0100011000 -> back to HUNT, no data_valid.
REQ-035 bit_en toggling 1-of-3 cycles during locked stream -> same decoded bytes as continuous bit_en.
REQ-036 rst_n asserted at bit 5 of a locked word -> all outputs reset immediately; no data_valid until re-lock.
